// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter sequencing four byte producers through a shared 4:1 selector
module mux_rr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [3:0]        last,
    output logic [3:0]        ack,
    output logic [3:0]        grant,
    output logic [1:0]        mux_sel,
    output logic              mux_en,
    input  logic [DATA_W-1:0] mux_y,
    output logic [DATA_W-1:0] y_data,
    output logic              y_valid,
    input  logic              y_ready
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    state_t     state;
    logic [1:0] ptr;
    logic [3:0] beat_cnt;
    logic       accept;
    logic       release_now;
    logic       pick_valid;
    logic [1:0] pick_idx;
    logic [1:0] idx;

    // mux_sel holds the granted index for the whole burst, so it doubles as g.
    assign accept = (state == BUSY) && req[mux_sel] && (!y_valid || y_ready);

    assign release_now = (state == BUSY) &&
                         (!req[mux_sel] ||
                          (accept && (last[mux_sel] || (beat_cnt + 4'd1 == MAX_CNT))));

    always_comb begin
        ack = 4'b0000;
        if (accept) begin
            ack[mux_sel] = 1'b1;
        end
    end

    // Scan from the farthest offset down so the nearest set bit after ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr;
        idx        = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= 4'b0000;
            mux_sel  <= 2'b00;
            mux_en   <= 1'b0;
            ptr      <= 2'b00;
            beat_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state    <= BUSY;
                        grant    <= 4'b0001 << pick_idx;
                        mux_sel  <= pick_idx;
                        mux_en   <= 1'b1;
                        beat_cnt <= 4'd0;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        state  <= IDLE;
                        grant  <= 4'b0000;
                        mux_en <= 1'b0;
                        ptr    <= mux_sel + 2'd1;
                    end
                    if (accept) begin
                        beat_cnt <= beat_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output stage drains independently of arbitration so the final beat survives release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_data  <= '0;
            y_valid <= 1'b0;
        end else if (accept) begin
            y_data  <= mux_y;
            y_valid <= 1'b1;
        end else if (y_valid && y_ready) begin
            y_valid <= 1'b0;
        end
    end

endmodule
